// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: default widths and the ALU opcode encoding.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned ALU_OP_W   = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OR   = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_NOR  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SUB  = 3'b111
    } alu_op_e;

    localparam logic [ALU_OP_W-1:0] BUBBLE_OP = ALU_OR;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source: EX/MEM over MEM/WB over registered data;
// register 0 is never forwarded and always reads as zero.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_wr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_wr,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] operand
);

    logic src_zero;

    assign src_zero = (src == '0);

    always_comb begin
        operand = reg_data;
        if (src_zero) begin
            operand = '0;
        end else if (exmem_wr && (exmem_rd == src)) begin
            operand = exmem_result;
        end else if (memwb_wr && (memwb_rd == src)) begin
            operand = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU; supports stall and flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_rs1_data,
    input  logic [DATA_W-1:0]   id_rs2_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_use_imm,
    input  logic                id_reg_write,
    input  logic [REG_AW-1:0]   exmem_rd,
    input  logic                exmem_wr,
    input  logic [DATA_W-1:0]   exmem_result,
    input  logic [REG_AW-1:0]   memwb_rd,
    input  logic                memwb_wr,
    input  logic [DATA_W-1:0]   memwb_result,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_reg_write,
    output logic                ex_valid
);

    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              use_imm_q;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              load_bubble;

    assign load_bubble = flush || (!stall && !id_valid);

    // Stall keeps control but re-latches forwarded operands so a retiring producer is not lost.
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            alu_op       <= BUBBLE_OP;
            ex_rd        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
        end else if (stall) begin
            rs1_data_q   <= fwd_a;
            rs2_data_q   <= fwd_b;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            alu_op       <= id_alu_op;
            ex_rd        <= id_rd;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rs1_data_q   <= id_rs1_data;
            rs2_data_q   <= id_rs2_data;
            imm_q        <= id_imm;
            use_imm_q    <= id_use_imm;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .src          (rs1_q),
        .reg_data     (rs1_data_q),
        .exmem_rd     (exmem_rd),
        .exmem_wr     (exmem_wr),
        .exmem_result (exmem_result),
        .memwb_rd     (memwb_rd),
        .memwb_wr     (memwb_wr),
        .memwb_result (memwb_result),
        .operand      (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .src          (rs2_q),
        .reg_data     (rs2_data_q),
        .exmem_rd     (exmem_rd),
        .exmem_wr     (exmem_wr),
        .exmem_result (exmem_result),
        .memwb_rd     (memwb_rd),
        .memwb_wr     (memwb_wr),
        .memwb_result (memwb_result),
        .operand      (fwd_b)
    );

    assign alu_a = fwd_a;
    assign alu_b = use_imm_q ? imm_q : fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table through a scoreboard queue, plus stall/flush sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [2:0]  id_alu_op;
    logic        id_use_imm;
    logic        id_reg_write;
    logic [4:0]  exmem_rd;
    logic        exmem_wr;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_wr;
    logic [31:0] memwb_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .exmem_rd(exmem_rd), .exmem_wr(exmem_wr), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_wr(memwb_wr), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [4:0]  rs2;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        ui;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        rw;
        logic [4:0]  xrd;
        logic        xwr;
        logic [31:0] xres;
        logic [4:0]  wrd;
        logic        wwr;
        logic [31:0] wres;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic [4:0]  erd;
        logic        erw;
        logic        ev;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".alu_a"}, alu_a, e.a);
        chk({tag, ".alu_b"}, alu_b, e.b);
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(e.op));
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(e.rd));
        chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                            input logic ui, input logic [4:0] rd, input logic [2:0] op,
                            input logic rw);
        id_valid = v; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_rd = rd; id_alu_op = op; id_reg_write = rw;
    endtask

    task automatic drive_fwd(input logic [4:0] xrd, input logic xwr, input logic [31:0] xres,
                             input logic [4:0] wrd, input logic wwr, input logic [31:0] wres);
        exmem_rd = xrd; exmem_wr = xwr; exmem_result = xres;
        memwb_rd = wrd; memwb_wr = wwr; memwb_result = wres;
    endtask

    initial begin
        exp_t e;
        //        v  rs1   d1       rs2   d2       imm           ui rd    op     rw  xrd   xwr xres     wrd   wwr wres     ea            eb            eop    erd   erw ev
        vecs[0] = '{1, 5'd3, 32'h5,  5'd4, 32'h7,  32'h0,        0, 5'd1, 3'b011, 1, 5'd0, 0, 32'h0,  5'd0, 0, 32'h0,  32'h5,        32'h7,        3'b011, 5'd1, 1, 1};
        vecs[1] = '{1, 5'd2, 32'h11, 5'd5, 32'h22, 32'h0,        0, 5'd6, 3'b010, 1, 5'd2, 1, 32'hAA, 5'd2, 1, 32'hBB, 32'hAA,       32'h22,       3'b010, 5'd6, 1, 1};
        vecs[2] = '{1, 5'd2, 32'h11, 5'd5, 32'h22, 32'h0,        0, 5'd6, 3'b010, 1, 5'd2, 0, 32'hAA, 5'd2, 1, 32'hBB, 32'hBB,       32'h22,       3'b010, 5'd6, 1, 1};
        vecs[3] = '{1, 5'd0, 32'h33, 5'd6, 32'h44, 32'h0,        0, 5'd7, 3'b100, 0, 5'd0, 1, 32'hFF, 5'd0, 0, 32'h0,  32'h0,        32'h44,       3'b100, 5'd7, 0, 1};
        vecs[4] = '{1, 5'd1, 32'h55, 5'd7, 32'h88, 32'hFFFFFFF0, 1, 5'd8, 3'b111, 1, 5'd7, 1, 32'h99, 5'd1, 1, 32'h66, 32'h66,       32'hFFFFFFF0, 3'b111, 5'd8, 1, 1};
        vecs[5] = '{0, 5'd3, 32'h12, 5'd4, 32'h34, 32'h56,       1, 5'd9, 3'b101, 1, 5'd3, 1, 32'hAB, 5'd4, 1, 32'hCD, 32'h0,        32'h0,        3'b000, 5'd0, 0, 0};
        vecs[6] = '{1, 5'd10,32'h1,  5'd0, 32'h77, 32'h0,        0, 5'd11,3'b001, 1, 5'd0, 0, 32'h0,  5'd0, 1, 32'hEE, 32'h1,        32'h0,        3'b001, 5'd11,1, 1};
        vecs[7] = '{1, 5'd9, 32'h2,  5'd9, 32'h3,  32'h0,        0, 5'd12,3'b110, 0, 5'd8, 1, 32'h44, 5'd9, 1, 32'hCC, 32'hCC,       32'hCC,       3'b110, 5'd12,0, 1};

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1, 5'd3, 32'hDEAD, 5'd4, 32'hBEEF, 32'h1234, 0, 5'd2, 3'b011, 1);
        drive_fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        e = '{32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0};
        check_all("reset", e);
        @(negedge clk);
        rst = 1'b0;

        // Table: ID captured on one edge, forwarding applied and outputs checked just after.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_id(vecs[i].v, vecs[i].rs1, vecs[i].d1, vecs[i].rs2, vecs[i].d2, vecs[i].imm,
                     vecs[i].ui, vecs[i].rd, vecs[i].op, vecs[i].rw);
            drive_fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
            sb.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].erd, vecs[i].erw, vecs[i].ev});
            @(posedge clk);
            #1;
            drive_fwd(vecs[i].xrd, vecs[i].xwr, vecs[i].xres, vecs[i].wrd, vecs[i].wwr, vecs[i].wres);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("vec%0d.sb_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_all($sformatf("vec%0d", i), e);
            end
        end

        // Stall: MEM/WB forwards 0x12 to rs2, producer retires after the first stalled edge.
        @(negedge clk);
        drive_id(1, 5'd3, 32'h10, 5'd8, 32'h01, 32'h0, 0, 5'd4, 3'b001, 1);
        drive_fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
        @(posedge clk);
        #1;
        drive_fwd(5'd0, 0, 32'h0, 5'd8, 1, 32'h12);
        #1;
        e = '{32'h10, 32'h12, 3'b001, 5'd4, 1'b1, 1'b1};
        check_all("stall0", e);
        @(negedge clk);
        stall = 1'b1;
        drive_id(1, 5'd5, 32'h999, 5'd6, 32'h888, 32'h777, 1, 5'd13, 3'b111, 0);
        @(posedge clk);
        #1;
        drive_fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
        #1;
        check_all("stall1", e);
        @(posedge clk);
        #2;
        check_all("stall2", e);

        // Stall and flush together: flush wins and loads a bubble.
        @(negedge clk);
        stall = 1'b1; flush = 1'b1;
        drive_id(1, 5'd3, 32'h10, 5'd8, 32'h01, 32'h0, 0, 5'd4, 3'b011, 1);
        @(posedge clk);
        #1;
        drive_fwd(5'd3, 1, 32'h5A, 5'd8, 1, 32'hA5);
        #1;
        e = '{32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0};
        check_all("flush", e);

        // Immediate is never forwarded even with an active rs2 forward.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        drive_id(1, 5'd4, 32'h3, 5'd8, 32'h9, 32'hFFFFFFF0, 1, 5'd14, 3'b011, 1);
        @(posedge clk);
        #1;
        drive_fwd(5'd8, 1, 32'h5A, 5'd4, 1, 32'hA5);
        #1;
        e = '{32'hA5, 32'hFFFFFFF0, 3'b011, 5'd14, 1'b1, 1'b1};
        check_all("imm", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
